rf_write_ctrl: RTL and testbench

Write-side controller for the integer register file. It merges three write sources into the single register-file write port plus the dedicated `$ra` port:
- the in-order pipeline writeback (WB stage);
- the link-address write from `jal`;
- results from the long-latency multiply/divide unit, buffered in a 2-entry FIFO.

It also maintains a pending-write scoreboard that decode uses to stall on registers awaiting a long-latency result.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_write_ctrl_if.sv | 51 +++++
 rtl/lr_result_fifo.sv | 66 ++++++
 rtl/rf_write_ctrl.sv | 109 ++++++++++
 tb/tb_rf_write_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file write-side types and constants.
// Widths here are the defaults every rf_* block is built with.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] RA_REG   = 5'd31;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  // One general-port write: enable, destination, payload.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_ctrl_if.sv
// Bundle of all write sources, the long-latency handshake and the register-file
// write ports. master drives requests; slave is the write controller.
interface rf_write_ctrl_if #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int REG_AW = rf_pkg::REG_AW
);

  logic                       wb_valid;
  logic [REG_AW-1:0]          wb_rd;
  logic [DATA_W-1:0]          wb_data;

  logic                       jal_valid;
  logic [DATA_W-1:0]          jal_ra;

  logic                       lr_issue;
  logic [REG_AW-1:0]          lr_issue_rd;

  logic                       lr_valid;
  logic                       lr_ready;
  logic [REG_AW-1:0]          lr_rd;
  logic [DATA_W-1:0]          lr_data;

  logic                       rf_we;
  logic [REG_AW-1:0]          rf_waddr;
  logic [DATA_W-1:0]          rf_wdata;
  logic                       rf_jal_we;
  logic [DATA_W-1:0]          rf_jal_data;

  logic [(1 << REG_AW)-1:0]   pend_mask;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output jal_valid, jal_ra,
    output lr_issue, lr_issue_rd,
    output lr_valid, lr_rd, lr_data,
    input  lr_ready,
    input  rf_we, rf_waddr, rf_wdata, rf_jal_we, rf_jal_data,
    input  pend_mask
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  jal_valid, jal_ra,
    input  lr_issue, lr_issue_rd,
    input  lr_valid, lr_rd, lr_data,
    output lr_ready,
    output rf_we, rf_waddr, rf_wdata, rf_jal_we, rf_jal_data,
    output pend_mask
  );

endinterface

// File: rtl/lr_result_fifo.sv
// Small synchronous FIFO buffering long-latency results until the general
// write port has a free slot. Head entry is visible combinationally.
module lr_result_fifo #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int REG_AW = rf_pkg::REG_AW,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [REG_AW-1:0] head_rd,
  output logic [DATA_W-1:0] head_data
);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DEPTH-1:0]  valid_q;
  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full      = valid_q[wr_ptr];
  assign empty     = !valid_q[rd_ptr];
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: storage has no reset; valid_q alone decides whether an entry is live,
  // which keeps the array mappable to plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write controller: arbitrates pipeline writeback, jal link and
// buffered long-latency results, and tracks pending long-latency destinations.
module rf_write_ctrl #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int REG_AW   = rf_pkg::REG_AW,
  parameter int LR_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  rf_write_ctrl_if.slave bus
);

  import rf_pkg::*;

  localparam int REGS = 1 << REG_AW;

  logic              fifo_full;
  logic              fifo_empty;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  logic              wb_free;
  logic              head_hold;
  logic              drain;
  logic              push;

  wr_req_t           gen_d;
  wr_req_t           gen_q;
  logic              jal_we_q;
  logic [DATA_W-1:0] jal_data_q;
  logic [REGS-1:0]   pend_d;
  logic [REGS-1:0]   pend_q;

  // A wb_rd of zero is a discarded write, so it leaves the general slot open.
  assign wb_free   = !bus.wb_valid || (bus.wb_rd == ZERO_REG);
  // A $31 result waits one cycle behind a jal so the link write is never shadowed.
  assign head_hold = (head_rd == RA_REG) && bus.jal_valid;
  assign drain     = !fifo_empty && wb_free && !head_hold;

  // Ready reflects the registered full flag; a drain frees space only next cycle.
  assign bus.lr_ready = !fifo_full;
  assign push         = bus.lr_valid && !fifo_full && (bus.lr_rd != ZERO_REG);

  lr_result_fifo #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (LR_DEPTH)
  ) u_lr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (bus.lr_rd),
    .push_data (bus.lr_data),
    .pop       (drain),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_rd   (head_rd),
    .head_data (head_data)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gen_d = '0;
    if (!wb_free) begin
      gen_d = '{valid: 1'b1, rd: bus.wb_rd, data: bus.wb_data};
    end else if (drain) begin
      gen_d = '{valid: 1'b1, rd: head_rd, data: head_data};
    end
  end

  // Clear on drain first, then set on issue, so a same-register collision keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (drain) begin
      pend_d[head_rd] = 1'b0;
    end
    if (bus.lr_issue && (bus.lr_issue_rd != ZERO_REG)) begin
      pend_d[bus.lr_issue_rd] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_q      <= '0;
      jal_we_q   <= 1'b0;
      jal_data_q <= '0;
      pend_q     <= '0;
    end else begin
      gen_q    <= gen_d;
      jal_we_q <= bus.jal_valid;
      if (bus.jal_valid) begin
        jal_data_q <= bus.jal_ra;
      end
      pend_q <= pend_d;
    end
  end

  assign bus.rf_we       = gen_q.valid;
  assign bus.rf_waddr    = gen_q.rd;
  assign bus.rf_wdata    = gen_q.data;
  assign bus.rf_jal_we   = jal_we_q;
  assign bus.rf_jal_data = jal_data_q;
  assign bus.pend_mask   = pend_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl with a queue-based reference model compared
// every cycle, plus literal expectations for the key scenarios.
module tb_rf_write_ctrl;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int LR_DEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rf_write_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  rf_write_ctrl #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .LR_DEPTH (LR_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered results and a set of pending registers.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we       = 1'b0;
  logic [4:0]  m_waddr    = '0;
  logic [31:0] m_wdata    = '0;
  logic        m_jal_we   = 1'b0;
  logic [31:0] m_jal_data = '0;
  logic [31:0] m_pend     = '0;

  always @(posedge clk or posedge reset) begin
    logic wb_busy;
    logic take;
    logic accept;
    ent_t e;
    if (reset) begin
      q.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      m_jal_we = 1'b0; m_jal_data = '0; m_pend = '0;
    end else begin
      wb_busy = bus.wb_valid && (bus.wb_rd != 5'd0);
      take    = (q.size() > 0) && !wb_busy && !((q[0].rd == 5'd31) && bus.jal_valid);
      accept  = bus.lr_valid && (q.size() < LR_DEPTH) && (bus.lr_rd != 5'd0);
      m_we = 1'b0;
      if (wb_busy) begin
        m_we = 1'b1; m_waddr = bus.wb_rd; m_wdata = bus.wb_data;
      end else if (take) begin
        m_we = 1'b1; m_waddr = q[0].rd; m_wdata = q[0].data;
      end
      m_jal_we = bus.jal_valid;
      if (bus.jal_valid) m_jal_data = bus.jal_ra;
      if (take) begin
        m_pend[q[0].rd] = 1'b0;
        void'(q.pop_front());
      end
      if (bus.lr_issue && (bus.lr_issue_rd != 5'd0)) m_pend[bus.lr_issue_rd] = 1'b1;
      if (accept) begin
        e.rd = bus.lr_rd; e.data = bus.lr_data;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    check("rf_we", bus.rf_we, m_we);
    check("lr_ready", bus.lr_ready, q.size() < LR_DEPTH);
    check("rf_jal_we", bus.rf_jal_we, m_jal_we);
    check("pend_mask", bus.pend_mask, m_pend);
    if (m_we) begin
      check("rf_waddr", bus.rf_waddr, m_waddr);
      check("rf_wdata", bus.rf_wdata, m_wdata);
    end
    if (m_jal_we) check("rf_jal_data", bus.rf_jal_data, m_jal_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.jal_valid = 1'b0; bus.jal_ra = '0;
    bus.lr_issue = 1'b0; bus.lr_issue_rd = '0;
    bus.lr_valid = 1'b0; bus.lr_rd = '0; bus.lr_data = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.lr_issue = 1'b1; bus.lr_issue_rd = rd;
    step();
    bus.lr_issue = 1'b0;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", bus.rf_we, 1'b0);
    check("reset rf_waddr", bus.rf_waddr, 5'd0);
    check("reset rf_wdata", bus.rf_wdata, 32'd0);
    check("reset rf_jal_we", bus.rf_jal_we, 1'b0);
    check("reset rf_jal_data", bus.rf_jal_data, 32'd0);
    check("reset pend_mask", bus.pend_mask, 32'd0);
    check("reset lr_ready", bus.lr_ready, 1'b1);
    #2 reset = 1'b0;
    step();

    // Single long-latency result through an idle pipeline.
    issue(5'd8);
    check("t1 pend set", bus.pend_mask, 32'h0000_0100);
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd8; bus.lr_data = 32'hDEAD_BEEF;
    step();
    bus.lr_valid = 1'b0;
    check("t1 no bypass", bus.rf_we, 1'b0);
    step();
    check("t1 we", bus.rf_we, 1'b1);
    check("t1 waddr", bus.rf_waddr, 5'd8);
    check("t1 wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    check("t1 pend clear", bus.pend_mask, 32'd0);
    step();
    check("t1 idle we", bus.rf_we, 1'b0);

    // WB holds the port for 4 cycles; the buffered result waits.
    issue(5'd9);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd5;
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd9; bus.lr_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.lr_valid = 1'b0;
      check("t2 wb addr", bus.rf_waddr, 5'd3);
      check("t2 wb data", bus.rf_wdata, 32'd5);
    end
    bus.wb_valid = 1'b0;
    step();
    check("t2 lr we", bus.rf_we, 1'b1);
    check("t2 lr addr", bus.rf_waddr, 5'd9);
    check("t2 lr data", bus.rf_wdata, 32'h99);
    step();

    // Fill the FIFO behind a busy WB, hold a third result, then drain in order.
    issue(5'd10); issue(5'd11); issue(5'd12);
    check("t3 pend", bus.pend_mask, 32'h0000_1C00);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'd7;
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd10; bus.lr_data = 32'hA0;
    step();
    bus.lr_rd = 5'd11; bus.lr_data = 32'hB0;
    step();
    check("t3 full", bus.lr_ready, 1'b0);
    bus.lr_rd = 5'd12; bus.lr_data = 32'hC0;
    step();
    step();
    check("t3 still full", bus.lr_ready, 1'b0);
    check("t3 wb addr", bus.rf_waddr, 5'd4);
    bus.wb_valid = 1'b0;
    step();
    check("t3 first addr", bus.rf_waddr, 5'd10);
    check("t3 first data", bus.rf_wdata, 32'hA0);
    check("t3 ready back", bus.lr_ready, 1'b1);
    step();
    bus.lr_valid = 1'b0;
    check("t3 second addr", bus.rf_waddr, 5'd11);
    step();
    check("t3 third addr", bus.rf_waddr, 5'd12);
    check("t3 third data", bus.rf_wdata, 32'hC0);
    step();
    check("t3 drained we", bus.rf_we, 1'b0);
    check("t3 drained pend", bus.pend_mask, 32'd0);

    // jal collides with a $31 FIFO head: link first, result one cycle later.
    issue(5'd31);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'd1;
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd31; bus.lr_data = 32'hAAAA;
    step();
    bus.wb_valid = 1'b0; bus.lr_valid = 1'b0;
    bus.jal_valid = 1'b1; bus.jal_ra = 32'h0040_0010;
    step();
    bus.jal_valid = 1'b0;
    check("t4 jal we", bus.rf_jal_we, 1'b1);
    check("t4 jal data", bus.rf_jal_data, 32'h0040_0010);
    check("t4 held we", bus.rf_we, 1'b0);
    step();
    check("t4 ra we", bus.rf_we, 1'b1);
    check("t4 ra addr", bus.rf_waddr, 5'd31);
    check("t4 ra data", bus.rf_wdata, 32'hAAAA);
    check("t4 jal off", bus.rf_jal_we, 1'b0);

    // Result for $0 is accepted and dropped.
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd0; bus.lr_data = 32'h1234;
    check("t5 ready", bus.lr_ready, 1'b1);
    step();
    bus.lr_valid = 1'b0;
    step();
    check("t5 no we", bus.rf_we, 1'b0);
    check("t5 empty", bus.lr_ready, 1'b1);
    check("t5 pend", bus.pend_mask, 32'd0);

    // Reset with two results buffered.
    issue(5'd20); issue(5'd21);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'd2;
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd20; bus.lr_data = 32'h20;
    step();
    bus.lr_rd = 5'd21; bus.lr_data = 32'h21;
    step();
    bus.lr_valid = 1'b0;
    check("t6 full", bus.lr_ready, 1'b0);
    check("t6 pend", bus.pend_mask, 32'h0030_0000);
    #2;
    bus.wb_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t6 rst we", bus.rf_we, 1'b0);
    check("t6 rst waddr", bus.rf_waddr, 5'd0);
    check("t6 rst wdata", bus.rf_wdata, 32'd0);
    check("t6 rst jal", bus.rf_jal_we, 1'b0);
    check("t6 rst pend", bus.pend_mask, 32'd0);
    check("t6 rst ready", bus.lr_ready, 1'b1);
    step();
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6 no stale we", bus.rf_we, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
